// File: rtl/ram_async_if.sv
// ram_async_if
//   Bus bundle for the 16x8 register-file RAM: one shared address, write data,
//   write enable and combinational read data.
//   Ports (signals):
//     addr      address shared by read and write
//     data_in   write data
//     we        write enable, active-high
//     data_out  read data, mem[addr], combinational
//   Modports:
//     master  drives addr/data_in/we, observes data_out
//     slave   the RAM side
interface ram_async_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output addr,
    output data_in,
    output we,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  we,
    output data_out
  );
endinterface

// File: rtl/ram_async.sv
// ram_async
//   16x8 register-file RAM with synchronous write and asynchronous read.
//   Storage is built from flops so a synchronous reset can clear every word.
//   Ports:
//     clk    clock, all state changes on the rising edge
//     rst_n  synchronous active-low reset, clears all entries, beats we
//     bus    ram_async_if slave: addr, data_in, we in; data_out out
//   Read data follows addr combinationally; a write to the address being read
//   shows up only after the edge that performs it (no write-through bypass).
module ram_async #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_async_if.slave   bus
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset has priority over a write issued in the same cycle; that write is
  // simply lost and must be re-issued by the requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  // DEPTH covers the whole address space, so no range check is needed.
  assign bus.data_out = mem[bus.addr];

endmodule

// File: tb/tb_ram_async.sv
module tb_ram_async;

  logic clk;
  logic rst_n;

  ram_async_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  ram_async #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain array of words, updated with the RAM's documented rules.
  logic [7:0] model [16];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle; the model applies the edge's effect, then we sit
  // 1 ns past the edge so reads are away from it.
  task automatic cycle(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    rst_n       = r;
    bus.we      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
    end else if (w) begin
      model[a] = d;
    end
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a);
    bus.addr = a;
    #1;
    chk(tag, bus.data_out, model[a]);
  endtask

  initial begin
    logic [7:0] wr_vals [5];
    logic [3:0] ra;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       wr;
    logic       rs;

    wr_vals[0] = 8'd55; wr_vals[1] = 8'd99; wr_vals[2] = 8'd150;
    wr_vals[3] = 8'd200; wr_vals[4] = 8'd77;
    rst_n = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;

    // 1: reset, then sweep - every word reads 0
    cycle(1'b0, 1'b0, 4'd0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.addr = 4'(i);
      #1;
      chk("reset_sweep", bus.data_out, 8'h00);
    end

    // 2: five writes on consecutive edges, then reads with no edge in between
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 4'(i), wr_vals[i]);
    bus.we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.addr = 4'(i);
      #2;
      chk("async_read", bus.data_out, wr_vals[i]);
    end

    // 3: we=0 across edges leaves mem[2] alone
    cycle(1'b1, 1'b0, 4'd2, 8'hFF);
    cycle(1'b1, 1'b0, 4'd2, 8'hFF);
    chk("no_write", bus.data_out, 8'd150);

    // 4: read-during-write, old word before edge, new word after
    rst_n = 1'b1; bus.we = 1'b1; bus.addr = 4'd3; bus.data_in = 8'h5A;
    #2;
    chk("rdw_before", bus.data_out, 8'd200);
    cycle(1'b1, 1'b1, 4'd3, 8'h5A);
    chk("rdw_after", bus.data_out, 8'h5A);

    // 5: boundary addresses
    cycle(1'b1, 1'b1, 4'd15, 8'hA5);
    cycle(1'b1, 1'b1, 4'd0, 8'h3C);
    bus.we = 1'b0;
    bus.addr = 4'd15; #1; chk("top_addr", bus.data_out, 8'hA5);
    bus.addr = 4'd0;  #1; chk("bot_addr", bus.data_out, 8'h3C);
    bus.addr = 4'd1;  #1; chk("addr1_kept", bus.data_out, 8'd99);

    // 6: reset beats a simultaneous write
    cycle(1'b0, 1'b1, 4'd1, 8'h11);
    rst_n = 1'b1; bus.we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.addr = 4'(i);
      #1;
      chk("rst_over_we", bus.data_out, 8'h00);
    end
    cycle(1'b1, 1'b1, 4'd1, 8'h22);
    bus.we = 1'b0;
    chk("post_rst_write", bus.data_out, 8'h22);
    read_chk("post_rst_model", 4'd1);

    // Random traffic against the model, including occasional resets
    for (int n = 0; n < 400; n++) begin
      rs = ($urandom_range(0, 24) != 0);
      wr = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      rst_n = rs; bus.we = wr; bus.addr = wa; bus.data_in = wd;
      #1;
      chk("rnd_pre_edge", bus.data_out, model[wa]);
      cycle(rs, wr, wa, wd);
      bus.we = 1'b0;
      chk("rnd_post_edge", bus.data_out, model[wa]);
      ra = 4'($urandom_range(0, 15));
      read_chk("rnd_read", ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
